// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-side handshake signals of the memory port arbiter.
// The master modport is the arbiter's view; slave is the core/memory environment's view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_wr;
    logic [1:0]        d_size;
    logic              d_zero_ex;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;

    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    logic              stall;

    modport master (
        input  if_req, if_addr, d_req, d_wr, d_size, d_zero_ex, d_addr, d_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata, stall
    );

    modport slave (
        output if_req, if_addr, d_req, d_wr, d_size, d_zero_ex, d_addr, d_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fixed-priority (data over fetch) arbiter onto one single-port memory, one outstanding
// transaction, with byte-lane store alignment and sign/zero-extended load extraction.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input logic                clk,
    input logic                rst_n,
    mem_port_arbiter_if.master bus
);
    if (DATA_W != 32) begin : g_bad_data_w
        $error("mem_port_arbiter: DATA_W must be 32");
    end

    typedef enum logic [2:0] {StIdle, StReqD, StReqI, StWaitD, StWaitI} state_e;

    state_e      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        zx_q, zx_d;
    logic        wr_q, wr_d;

    logic        d_misaligned;
    logic [3:0]  d_be;
    logic [31:0] d_wdata_rep;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic        unused_if_addr;

    assign unused_if_addr = ^bus.if_addr[1:0];

    assign d_misaligned = ((bus.d_size == 2'b01) && bus.d_addr[0]) ||
                          (bus.d_size[1] && (bus.d_addr[1:0] != 2'b00));

    always_comb begin
        d_be        = 4'hF;
        d_wdata_rep = bus.d_wdata;
        case (bus.d_size)
            2'b00: begin
                d_be        = 4'b0001 << bus.d_addr[1:0];
                d_wdata_rep = {4{bus.d_wdata[7:0]}};
            end
            2'b01: begin
                d_be        = 4'b0011 << {bus.d_addr[1], 1'b0};
                d_wdata_rep = {2{bus.d_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = bus.mem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_data = bus.mem_rdata;
        case (size_q)
            2'b00:   load_data = {{24{~zx_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{~zx_q & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        size_d        = size_q;
        off_d         = off_q;
        zx_d          = zx_q;
        wr_d          = wr_q;
        bus.if_gnt    = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.d_gnt     = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = '0;
        bus.d_err     = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.d_req && !d_misaligned) begin
                    state_d = StReqD;
                end else begin
                    // A rejected data access still lets a waiting fetch through this cycle.
                    bus.d_err = bus.d_req & rst_n;
                    if (bus.if_req) state_d = StReqI;
                end
            end
            StReqD: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = bus.d_wr;
                bus.mem_be    = d_be;
                bus.mem_addr  = {bus.d_addr[ADDR_W-1:2], 2'b00};
                bus.mem_wdata = d_wdata_rep;
                if (bus.mem_ready) begin
                    bus.d_gnt = 1'b1;
                    size_d    = bus.d_size;
                    off_d     = bus.d_addr[1:0];
                    zx_d      = bus.d_zero_ex;
                    wr_d      = bus.d_wr;
                    state_d   = StWaitD;
                end
            end
            StReqI: begin
                bus.mem_req  = 1'b1;
                bus.mem_be   = 4'hF;
                bus.mem_addr = {bus.if_addr[ADDR_W-1:2], 2'b00};
                if (bus.mem_ready) begin
                    bus.if_gnt = 1'b1;
                    state_d    = StWaitI;
                end
            end
            StWaitD: begin
                if (bus.mem_rvalid) begin
                    bus.d_rvalid = 1'b1;
                    bus.d_rdata  = wr_q ? 32'h0 : load_data;
                    state_d      = StIdle;
                end
            end
            StWaitI: begin
                if (bus.mem_rvalid) begin
                    bus.if_rvalid = 1'b1;
                    bus.if_rdata  = bus.mem_rdata;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.stall = rst_n & ((bus.if_req & ~bus.if_rvalid) |
                                (bus.d_req & ~bus.d_rvalid & ~bus.d_err));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            size_q  <= '0;
            off_q   <= '0;
            zx_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            off_q   <= off_d;
            zx_q    <= zx_d;
            wr_q    <= wr_d;
        end
    end

    a_d_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StReqD) |-> bus.d_req);
    a_if_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StReqI) |-> bus.if_req);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of data transactions plus hand-written
// sequences for fetch, priority, misaligned-with-fetch, back-pressure and mid-flight reset.
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    mem_port_arbiter_if #(.ADDR_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic        zx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic zx,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic err,
                                input logic [3:0] be, input logic [31:0] mwdata,
                                input logic [31:0] exp);
        vec_t v;
        v.wr = wr; v.size = size; v.zx = zx; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.be = be; v.mwdata = mwdata; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_vec(input int idx, input vec_t v);
        bus.d_req      = 1'b1;
        bus.d_wr       = v.wr;
        bus.d_size     = v.size;
        bus.d_zero_ex  = v.zx;
        bus.d_addr     = v.addr;
        bus.d_wdata    = v.wdata;
        bus.mem_ready  = 1'b1;
        bus.mem_rvalid = 1'b0;
        #1;
        if (v.err) begin
            chk($sformatf("v%0d_err", idx), {31'b0, bus.d_err}, 32'd1);
            chk($sformatf("v%0d_err_noreq", idx), {31'b0, bus.mem_req}, 32'd0);
            chk($sformatf("v%0d_err_stall", idx), {31'b0, bus.stall}, 32'd0);
            tick;
            bus.d_req = 1'b0;
            #1;
            chk($sformatf("v%0d_err_after", idx), {30'b0, bus.d_err, bus.mem_req}, 32'd0);
        end else begin
            chk($sformatf("v%0d_idle", idx), {30'b0, bus.d_err, bus.stall}, 32'd1);
            tick;
            #1;
            chk($sformatf("v%0d_gnt", idx), {29'b0, bus.d_gnt, bus.mem_req, bus.mem_we},
                {30'b011, v.wr});
            chk($sformatf("v%0d_be", idx), {28'b0, bus.mem_be}, {28'b0, v.be});
            chk($sformatf("v%0d_addr", idx), bus.mem_addr, v.addr & ~32'h3);
            chk($sformatf("v%0d_wdata", idx), bus.mem_wdata, v.mwdata);
            tick;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = v.rdata;
            #1;
            chk($sformatf("v%0d_rvalid", idx), {30'b0, bus.d_rvalid, bus.stall}, 32'd2);
            chk($sformatf("v%0d_rdata", idx), bus.d_rdata, v.exp);
            tick;
            bus.d_req      = 1'b0;
            bus.mem_rvalid = 1'b0;
            #1;
            chk($sformatf("v%0d_done", idx), {30'b0, bus.mem_req, bus.d_rvalid}, 32'd0);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        //             wr    size  zx    addr          wdata         rdata         err   be       mwdata        exp
        vecs[0]  = mk(1'b1, 2'b00, 1'b0, 32'h0000_0203, 32'h1234_56AB, 32'hDEAD_BEEF, 1'b0, 4'b1000, 32'hABAB_ABAB, 32'h0);
        vecs[1]  = mk(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'hFFFF_1234, 32'hDEAD_BEEF, 1'b0, 4'b1100, 32'h1234_1234, 32'h0);
        vecs[2]  = mk(1'b1, 2'b01, 1'b0, 32'h0000_0200, 32'h0000_BEEF, 32'h0,         1'b0, 4'b0011, 32'hBEEF_BEEF, 32'h0);
        vecs[3]  = mk(1'b1, 2'b10, 1'b0, 32'h0000_0204, 32'hCAFE_F00D, 32'h0,         1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0);
        vecs[4]  = mk(1'b1, 2'b00, 1'b0, 32'h0000_0200, 32'h0000_005A, 32'h0,         1'b0, 4'b0001, 32'h5A5A_5A5A, 32'h0);
        vecs[5]  = mk(1'b0, 2'b00, 1'b0, 32'h0000_0202, 32'h0,         32'h80FF_7F01, 1'b0, 4'b0100, 32'h0,         32'hFFFF_FFFF);
        vecs[6]  = mk(1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0,         32'h80FF_7F01, 1'b0, 4'b1000, 32'h0,         32'h0000_0080);
        vecs[7]  = mk(1'b0, 2'b01, 1'b0, 32'h0000_0200, 32'h0,         32'h80FF_7F01, 1'b0, 4'b0011, 32'h0,         32'h0000_7F01);
        vecs[8]  = mk(1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0,         32'h80FF_7F01, 1'b0, 4'b1100, 32'h0,         32'h0000_80FF);
        vecs[9]  = mk(1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0,         32'h80FF_7F01, 1'b0, 4'b1100, 32'h0,         32'hFFFF_80FF);
        vecs[10] = mk(1'b0, 2'b00, 1'b0, 32'h0000_0201, 32'h0,         32'h80FF_7F01, 1'b0, 4'b0010, 32'h0,         32'h0000_007F);
        vecs[11] = mk(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0,         32'h80FF_7F01, 1'b0, 4'b1111, 32'h0,         32'h80FF_7F01);
        vecs[12] = mk(1'b0, 2'b11, 1'b1, 32'h0000_0208, 32'h0,         32'h8234_5678, 1'b0, 4'b1111, 32'h0,         32'h8234_5678);
        vecs[13] = mk(1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0,         32'h80FF_7F01, 1'b0, 4'b1000, 32'h0,         32'hFFFF_FF80);
        vecs[14] = mk(1'b0, 2'b10, 1'b0, 32'h0000_0201, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0);
        vecs[15] = mk(1'b0, 2'b01, 1'b0, 32'h0000_0203, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0);
        vecs[16] = mk(1'b1, 2'b10, 1'b0, 32'h0000_0206, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0);

        rst_n          = 1'b0;
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.d_req      = 1'b0;
        bus.d_wr       = 1'b0;
        bus.d_size     = 2'b00;
        bus.d_zero_ex  = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        #3;
        chk("rst_outs", {25'b0, bus.if_gnt, bus.if_rvalid, bus.d_gnt, bus.d_rvalid, bus.d_err,
                         bus.mem_req, bus.stall}, 32'd0);
        tick;
        tick;
        rst_n = 1'b1;

        // Fetch only.
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h100;
        bus.mem_ready = 1'b1;
        #1;
        chk("f_c0", {29'b0, bus.if_gnt, bus.mem_req, bus.stall}, 32'b001);
        tick;
        #1;
        chk("f_c1", {28'b0, bus.if_gnt, bus.mem_req, bus.mem_we, bus.stall}, 32'b1101);
        chk("f_c1_addr", bus.mem_addr, 32'h100);
        chk("f_c1_be", {28'b0, bus.mem_be}, 32'hF);
        tick;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0050_0093;
        #1;
        chk("f_c2", {29'b0, bus.if_rvalid, bus.if_gnt, bus.stall}, 32'b100);
        chk("f_c2_rdata", bus.if_rdata, 32'h0050_0093);
        tick;
        bus.if_req     = 1'b0;
        bus.mem_rvalid = 1'b0;

        // Spurious response while idle.
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        #1;
        chk("spur_idle", {30'b0, bus.if_rvalid, bus.d_rvalid}, 32'd0);
        tick;
        bus.mem_rvalid = 1'b0;

        for (int i = 0; i < 17; i++) do_vec(i, vecs[i]);

        // Simultaneous fetch and data load: data first.
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h104;
        bus.d_req     = 1'b1;
        bus.d_wr      = 1'b0;
        bus.d_size    = 2'b10;
        bus.d_zero_ex = 1'b0;
        bus.d_addr    = 32'h200;
        #1;
        tick;
        #1;
        chk("pri_c1", {30'b0, bus.d_gnt, bus.if_gnt}, 32'b10);
        chk("pri_c1_addr", bus.mem_addr, 32'h200);
        tick;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1122_3344;
        #1;
        chk("pri_c2", {29'b0, bus.d_rvalid, bus.if_rvalid, bus.if_gnt}, 32'b100);
        chk("pri_c2_rdata", bus.d_rdata, 32'h1122_3344);
        tick;
        bus.d_req      = 1'b0;
        bus.mem_rvalid = 1'b0;
        #1;
        chk("pri_c3", {29'b0, bus.mem_req, bus.if_gnt, bus.stall}, 32'b001);
        tick;
        #1;
        chk("pri_c4", {30'b0, bus.if_gnt, bus.mem_req}, 32'b11);
        chk("pri_c4_addr", bus.mem_addr, 32'h104);
        tick;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h5566_7788;
        #1;
        chk("pri_c5", {31'b0, bus.if_rvalid}, 32'd1);
        chk("pri_c5_rdata", bus.if_rdata, 32'h5566_7788);
        tick;
        bus.if_req     = 1'b0;
        bus.mem_rvalid = 1'b0;

        // Misaligned data access alongside a fetch: error now, fetch next.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h108;
        bus.d_req   = 1'b1;
        bus.d_size  = 2'b10;
        bus.d_addr  = 32'h202;
        #1;
        chk("mis_c0", {29'b0, bus.d_err, bus.mem_req, bus.stall}, 32'b101);
        tick;
        bus.d_req = 1'b0;
        #1;
        chk("mis_c1", {29'b0, bus.if_gnt, bus.d_err, bus.d_gnt}, 32'b100);
        chk("mis_c1_addr", bus.mem_addr, 32'h108);
        tick;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hA5A5_0001;
        #1;
        chk("mis_c2", {31'b0, bus.if_rvalid}, 32'd1);
        tick;
        bus.if_req     = 1'b0;
        bus.mem_rvalid = 1'b0;

        // Back-pressure for five cycles, then reset while waiting for the response.
        bus.mem_ready = 1'b0;
        bus.d_req     = 1'b1;
        bus.d_wr      = 1'b1;
        bus.d_size    = 2'b10;
        bus.d_addr    = 32'h208;
        bus.d_wdata   = 32'h1234_ABCD;
        #1;
        for (int c = 0; c < 5; c++) begin
            tick;
            #1;
            chk($sformatf("bp_c%0d", c), {29'b0, bus.mem_req, bus.mem_we, bus.d_gnt}, 32'b110);
            chk($sformatf("bp_c%0d_addr", c), bus.mem_addr, 32'h208);
            chk($sformatf("bp_c%0d_wdata", c), bus.mem_wdata, 32'h1234_ABCD);
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("bp_gnt", {31'b0, bus.d_gnt}, 32'd1);
        tick;
        #1;
        chk("bp_wait", {30'b0, bus.mem_req, bus.stall}, 32'b01);
        rst_n = 1'b0;
        #1;
        chk("rst_mid", {26'b0, bus.mem_req, bus.d_gnt, bus.d_rvalid, bus.d_err, bus.stall,
                        bus.if_gnt}, 32'd0);
        chk("rst_mid_be", {28'b0, bus.mem_be}, 32'd0);
        tick;
        tick;
        rst_n     = 1'b1;
        bus.d_req = 1'b0;
        tick;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h8765_4321;
        #1;
        chk("rst_late_rvalid", {30'b0, bus.d_rvalid, bus.if_rvalid}, 32'd0);
        chk("rst_late_rdata", bus.d_rdata, 32'd0);
        tick;
        bus.mem_rvalid = 1'b0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
